branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Sits between the gshare predictor and the execute-stage branch unit.
- Records each fetched branch's PC and 1-bit direction prediction in program order.
- On in-order resolution from execute, compares the actual outcome with the recorded prediction, drives the predictor's update interface (update_en / update_val plus the PC to index with), and raises a registered mispredict/flush.
- Keeps resolve and mispredict statistics counters.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, >= 2.
- CNT_NBITS, 16, width of statistics counters.

Ports:
- clk  input  1  clock; all state rises on posedge.
- reset  input  1  asynchronous, active-low reset; state cleared while reset==0.
- enq_val  input  1  fetch presents a predicted branch.
- enq_rdy  output  1  entry available; equals !full, no combinational dependence on res_* or squash.
- enq_pc  input  32  branch PC.
- enq_pred  input  1  predictor output captured at fetch (1 = taken).
- res_val  input  1  execute resolves the oldest branch this cycle.
- res_taken  input  1  actual direction.
- squash  input  1  external flush (exception/redirect from later stage); clears queue.
- upd_en  output  1  registered; drives predictor update_en.
- upd_val  output  1  registered; actual direction, drives predictor update_val.
- upd_pc  output  32  registered; PC the predictor must index with during the update cycle.
- mispredict  output  1  registered; one-cycle pulse, prediction != outcome.
- count  output  $clog2(DEPTH+1)  current occupancy.
- resolve_cnt  output  CNT_NBITS  total accepted resolves, wraps.
- mispred_cnt  output  CNT_NBITS  total mispredicts, wraps.
- err  output  1  sticky; set when res_val arrives while empty.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc[31:0], pred}.
  - Head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH.
  - Occupancy counter is kept separately.
- Reset (reset==0, async):
  - head = tail = count = 0.
  - upd_en = upd_val = mispredict = err = 0; upd_pc = 0.
  - resolve_cnt = mispred_cnt = 0.
  - enq_rdy reads 1 immediately after reset deasserts.
- Enqueue: fires when enq_val && enq_rdy. Writes the entry at tail; tail+1.
- Resolve: fires when res_val && count != 0. Reads the entry at head; head+1.
  - Next cycle: upd_en=1, upd_val=res_taken, upd_pc=head.pc, mispredict=(head.pred != res_taken).
  - resolve_cnt += 1; mispred_cnt += 1 if mispredict.
  - Latency: resolve cycle N -> outputs valid cycle N+1, high for exactly one cycle.
- Resolve while empty:
  - No pointer change; upd_en stays 0.
  - err set to 1 and held until reset.
- Mispredict flush:
  - All entries younger than the resolved one are discarded in the resolve cycle itself: head = tail = count = 0 at the next edge.
  - An enqueue firing in the same cycle is also discarded.
- Squash:
  - Clears head/tail/count at the next edge. A same-cycle enqueue is discarded.
  - A same-cycle valid resolve is still reported on upd_* and counted; squash only drops younger entries.
- Simultaneous enqueue and resolve, no flush:
  - Both occur; count unchanged.
  - When full, enq_rdy=0 even if a resolve frees a slot that cycle; there is no bypass.
- Simultaneous resolve-mispredict and squash: same result as flush; the mispredict pulse is still generated.
- Count update: count_next = count + enq_fire - res_fire, or 0 on flush/squash.
- Counters wrap at 2^CNT_NBITS with no saturation.
- Reset mid-operation: all in-flight entries are lost, and any pending upd_en/mispredict pulse is cancelled immediately.
- No X propagation: entry storage is not reset, but it is never read unless count != 0.

Decomposition:
- Shared package lab4_branch_pkg holds:
  - typedef br_entry_t {logic [31:0] pc; logic pred;}.
  - Constant BR_PC_NBITS = 32.
  - Function for next-pointer wrap.
- One natural sub-module: branch_resolve_queue_stats.
  - Contains resolve_cnt, mispred_cnt and sticky err.
  - Driven by res_fire, mispredict_next and res_empty_err strobes.
- Storage and pointers stay in the top module.

Test Plan:
- Reset, then enq pc=0x100 pred=1; resolve taken=1 -> next cycle upd_en=1, upd_val=1, upd_pc=0x100, mispredict=0, resolve_cnt=1, count=0.
- Enq 0x200 pred=0, 0x204 pred=1, 0x208 pred=1; resolve taken=1 on the 0x200 entry -> mispredict=1, upd_pc=0x200, upd_val=1; following cycle count=0, mispred_cnt=1, enq_rdy=1.
- Fill DEPTH=4 entries (0x300..0x30C) -> enq_rdy=0, count=4. Same cycle enq_val=1 and correct resolve -> no enqueue, count=3. Next resolves return PCs 0x304, 0x308, 0x30C in order, testing wrap after 6+ total enqueues.
- Assert res_val with count=0 -> upd_en stays 0, err=1 and remains 1 through later traffic until reset.
- Enq 0x400, 0x404; assert squash together with a correct resolve of 0x400 -> upd_en=1, upd_pc=0x400, then count=0. The 0x404 entry is never resolved; resolve_cnt=1.
- Enqueue two entries, pull reset low mid-cycle (asynchronously) -> count=0, enq_rdy=1, all outputs 0 immediately, counters 0 after release.

Source files
------------

// File: rtl/lab4_branch_pkg.sv
// Shared types and helpers for the branch resolve queue: the entry layout
// and the circular-pointer advance.
package lab4_branch_pkg;

    localparam int unsigned BR_PC_NBITS = 32;

    typedef struct packed {
        logic [BR_PC_NBITS-1:0] pc;
        logic                   pred;
    } br_entry_t;

    function automatic int unsigned br_next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1) % depth;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_stats.sv
// Resolve/mispredict statistics and the sticky resolve-while-empty error flag.
module branch_resolve_queue_stats
    import lab4_branch_pkg::*;
#(
    parameter int unsigned CNT_NBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 res_fire,
    input  logic                 mispredict_next,
    input  logic                 res_empty_err,
    output logic [CNT_NBITS-1:0] resolve_cnt,
    output logic [CNT_NBITS-1:0] mispred_cnt,
    output logic                 err
);

    logic [CNT_NBITS-1:0] resolve_cnt_q;
    logic [CNT_NBITS-1:0] mispred_cnt_q;
    logic                 err_q;

    // Counters wrap freely; err only clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resolve_cnt_q <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (res_fire)        resolve_cnt_q <= resolve_cnt_q + 1'b1;
            if (mispredict_next) mispred_cnt_q <= mispred_cnt_q + 1'b1;
            if (res_empty_err)   err_q         <= 1'b1;
        end
    end

    assign resolve_cnt = resolve_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign err         = err_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; compares execute outcomes with the
// recorded prediction, drives predictor updates and flushes on mispredict.
module branch_resolve_queue
    import lab4_branch_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_NBITS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [BR_PC_NBITS-1:0]     enq_pc,
    input  logic                       enq_pred,
    input  logic                       res_val,
    input  logic                       res_taken,
    input  logic                       squash,
    output logic                       upd_en,
    output logic                       upd_val,
    output logic [BR_PC_NBITS-1:0]     upd_pc,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_NBITS-1:0]       resolve_cnt,
    output logic [CNT_NBITS-1:0]       mispred_cnt,
    output logic                       err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    br_entry_t mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic                   upd_en_q, upd_val_q, mispredict_q;
    logic [BR_PC_NBITS-1:0] upd_pc_q;

    logic      enq_fire, res_fire, res_empty_err, mispredict_next, flush;
    br_entry_t head_entry;

    // Full blocks enqueue even when a resolve frees a slot this cycle.
    assign enq_rdy       = (count_q != FULL_CNT);
    assign enq_fire      = enq_val && enq_rdy;
    assign res_fire      = res_val && (count_q != '0);
    assign res_empty_err = res_val && (count_q == '0);

    assign head_entry      = mem_q[head_q];
    assign mispredict_next = res_fire && (head_entry.pred != res_taken);
    assign flush           = squash || mispredict_next;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = PW'(br_next_ptr(32'(tail_q), DEPTH));
            if (res_fire) head_d = PW'(br_next_ptr(32'(head_q), DEPTH));
            count_d = count_q + CW'(enq_fire) - CW'(res_fire);
        end
    end

    // Entry storage is left unreset; it is only consumed when count != 0.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            mem_q[tail_q] <= '{pc: enq_pc, pred: enq_pred};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            upd_en_q     <= 1'b0;
            upd_val_q    <= 1'b0;
            upd_pc_q     <= '0;
            mispredict_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            upd_en_q     <= res_fire;
            mispredict_q <= mispredict_next;
            if (res_fire) begin
                upd_val_q <= res_taken;
                upd_pc_q  <= head_entry.pc;
            end
        end
    end

    assign upd_en     = upd_en_q;
    assign upd_val    = upd_val_q;
    assign upd_pc     = upd_pc_q;
    assign mispredict = mispredict_q;
    assign count      = count_q;

    branch_resolve_queue_stats #(
        .CNT_NBITS(CNT_NBITS)
    ) u_stats (
        .clk            (clk),
        .reset          (reset),
        .res_fire       (res_fire),
        .mispredict_next(mispredict_next),
        .res_empty_err  (res_empty_err),
        .resolve_cnt    (resolve_cnt),
        .mispred_cnt    (mispred_cnt),
        .err            (err)
    );

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench: driver updates a queue-based reference model per edge,
// monitor compares DUT outputs on the falling edge.
module tb_branch_resolve_queue;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_NBITS = 16;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       enq_val = 1'b0;
    logic                       enq_rdy;
    logic [31:0]                enq_pc = '0;
    logic                       enq_pred = 1'b0;
    logic                       res_val = 1'b0;
    logic                       res_taken = 1'b0;
    logic                       squash = 1'b0;
    logic                       upd_en;
    logic                       upd_val;
    logic [31:0]                upd_pc;
    logic                       mispredict;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [CNT_NBITS-1:0]       resolve_cnt;
    logic [CNT_NBITS-1:0]       mispred_cnt;
    logic                       err;

    branch_resolve_queue #(
        .DEPTH    (DEPTH),
        .CNT_NBITS(CNT_NBITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enq_val    (enq_val),
        .enq_rdy    (enq_rdy),
        .enq_pc     (enq_pc),
        .enq_pred   (enq_pred),
        .res_val    (res_val),
        .res_taken  (res_taken),
        .squash     (squash),
        .upd_en     (upd_en),
        .upd_val    (upd_val),
        .upd_pc     (upd_pc),
        .mispredict (mispredict),
        .count      (count),
        .resolve_cnt(resolve_cnt),
        .mispred_cnt(mispred_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    typedef struct {
        logic        val;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    int unsigned m_res = 0;
    int unsigned m_mis = 0;
    logic        m_err = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the cycle's inputs to the queue at the clock edge.
    task automatic model_edge();
        logic ef, rf, mis;
        ent_t e;
        ef  = enq_val && (mq.size() < DEPTH);
        rf  = res_val && (mq.size() > 0);
        mis = 1'b0;
        if (res_val && mq.size() == 0) m_err = 1'b1;
        if (rf) begin
            e   = mq.pop_front();
            mis = (e.pred != res_taken);
            sb.push_back('{val: res_taken, pc: e.pc, mis: mis});
            m_res++;
            if (mis) m_mis++;
        end
        if (squash || mis) mq.delete();
        else if (ef) mq.push_back('{pc: enq_pc, pred: enq_pred});
    endtask

    task automatic step(input logic ev, input logic [31:0] pc, input logic pr,
                        input logic rv, input logic tk, input logic sq);
        enq_val   = ev;
        enq_pc    = pc;
        enq_pred  = pr;
        res_val   = rv;
        res_taken = tk;
        squash    = sq;
        @(posedge clk);
        model_edge();
        #1;
        enq_val = 1'b0;
        res_val = 1'b0;
        squash  = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_res = 0;
        m_mis = 0;
        m_err = 1'b0;
    endtask

    // Monitor: every falling edge, pop one expected update when upd_en is high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (upd_en === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_upd actual=upd_en=1 required=upd_en=0 @%0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("upd_val", 32'(upd_val), 32'(e.val));
                    chk("upd_pc", upd_pc, e.pc);
                    chk("mispredict", 32'(mispredict), 32'(e.mis));
                end
            end else begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_upd actual=upd_en=0 required=upd_pc=%h @%0t",
                             e.pc, $time);
                end
                chk("mispredict_idle", 32'(mispredict), 32'd0);
            end
            chk("count", 32'(count), mq.size());
            chk("enq_rdy", 32'(enq_rdy), 32'(mq.size() < DEPTH));
            chk("resolve_cnt", 32'(resolve_cnt), 32'(CNT_NBITS'(m_res)));
            chk("mispred_cnt", 32'(mispred_cnt), 32'(CNT_NBITS'(m_mis)));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    initial begin
        int unsigned base_res;
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("rdy_after_reset", 32'(enq_rdy), 32'd1);

        // Single correctly predicted branch.
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_upd_en", 32'(upd_en), 32'd1);
        chk("t1_upd_pc", upd_pc, 32'h100);
        chk("t1_mispredict", 32'(mispredict), 32'd0);
        chk("t1_resolve_cnt", 32'(resolve_cnt), 32'd1);
        chk("t1_count", 32'(count), 32'd0);

        // Mispredict flushes younger entries.
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t2_mispredict", 32'(mispredict), 32'd1);
        chk("t2_upd_pc", upd_pc, 32'h200);
        chk("t2_upd_val", 32'(upd_val), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_count", 32'(count), 32'd0);
        chk("t2_mispred_cnt", 32'(mispred_cnt), 32'd1);
        chk("t2_enq_rdy", 32'(enq_rdy), 32'd1);

        // Fill, blocked enqueue on a full queue, then wrap the pointers.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_full_rdy", 32'(enq_rdy), 32'd0);
        chk("t3_full_count", 32'(count), 32'd4);
        step(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_count3", 32'(count), 32'd3);
        step(1'b1, 32'h310, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h314, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_drained", 32'(count), 32'd0);

        // Resolve while empty sets sticky err.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_upd_en", 32'(upd_en), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_err_sticky", 32'(err), 32'd1);

        // Squash with a same-cycle correct resolve.
        base_res = m_res;
        step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_upd_en", 32'(upd_en), 32'd1);
        chk("t5_upd_pc", upd_pc, 32'h400);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_resolve_cnt", 32'(resolve_cnt), 32'(CNT_NBITS'(base_res + 1)));

        // Asynchronous reset mid-cycle with an update pulse in flight.
        step(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_enq_rdy", 32'(enq_rdy), 32'd1);
        chk("t6_upd_en", 32'(upd_en), 32'd0);
        chk("t6_upd_pc", upd_pc, 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_resolve_cnt", 32'(resolve_cnt), 32'd0);
        chk("t6_mispred_cnt", 32'(mispred_cnt), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC, 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 19) == 0));
        end
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
